alu_result_display: RTL and testbench



---
 rtl/alu_disp_pkg.sv | 22 ++
 rtl/alu_result_display_hex7seg_decode.sv | 15 +
 rtl/alu_result_display.sv | 187 ++++++++++++++++++
 tb/tb_alu_result_display.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states,
// fixed segment patterns and the hex-to-7-segment table.
package alu_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SIGN = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // Segment patterns for 0..F, bit0=a .. bit6=g, active high
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/alu_result_display_hex7seg_decode.sv
// Combinational nibble to 7-segment decoder; feeds the display output register.
module hex7seg_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       unused_tie,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the nibble
    always_comb begin
        seg = HEX_SEG[nibble] | {6'b000000, unused_tie & 1'b0};
    end

endmodule

// File: rtl/alu_result_display.sv
// ALU result display: latches each result and shows high nibble, low nibble
// and a blank gap on one 7-segment digit. Optional macro DISP_SIGNED_EN adds a
// leading sign digit and shows the two's-complement magnitude.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 250,
    parameter int REPEAT       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [7:0] res_data,
    input  logic       res_carry,
    input  logic       res_zero,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic       busy_o
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PASS_W  = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [PASS_W-1:0] PASS_ONE   = PASS_W'(1);
    localparam logic [PASS_W-1:0] PASS_LAST  = PASS_W'((REPEAT > 0) ? REPEAT - 1 : 0);

`ifdef DISP_SIGNED_EN
    localparam state_t FIRST_ST = ST_SIGN;
`else
    localparam state_t FIRST_ST = ST_HI;
`endif

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [PASS_W-1:0] pass_r, pass_s;
    logic [7:0]        data_r, data_s;
    logic              carry_r, carry_s;
    logic              zero_r, zero_s;
    logic              end_pass_s;
    logic [7:0]        mag_s;
    logic [3:0]        nibble_s;
    logic [6:0]        seg_dec_s;

    assign res_ready = ena;

    // Next-state, counter and latch logic; everything holds while ena is low
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pass_s     = pass_r;
        data_s     = data_r;
        carry_s    = carry_r;
        zero_s     = zero_r;
        end_pass_s = 1'b0;
        if (ena && res_valid) begin
            // A new result preempts whatever is on display, including a dwell expiry
            state_s = FIRST_ST;
            cnt_s   = '0;
            pass_s  = '0;
            data_s  = res_data;
            carry_s = res_carry;
            zero_s  = res_zero;
        end else if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SIGN: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_s = ST_HI;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_s = ST_LO;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_LO: begin
                    if (cnt_r == DWELL_LAST) begin
                        if (BLANK_CYCLES > 0) begin
                            state_s = ST_GAP;
                            cnt_s   = '0;
                        end else begin
                            end_pass_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == BLANK_LAST) begin
                        end_pass_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
            if (end_pass_s) begin
                cnt_s = '0;
                if (REPEAT > 0) begin
                    pass_s  = pass_r + PASS_ONE;
                    state_s = (pass_r == PASS_LAST) ? ST_IDLE : FIRST_ST;
                end else begin
                    pass_s  = '0;
                    state_s = FIRST_ST;
                end
            end else begin
                pass_s = pass_r;
            end
        end else begin
            state_s = state_r;
        end
    end

`ifdef DISP_SIGNED_EN
    assign mag_s = data_s[7] ? (8'd0 - data_s) : data_s;
`else
    assign mag_s = data_s;
`endif

    assign nibble_s = (state_s == ST_HI) ? mag_s[7:4] : mag_s[3:0];

    hex7seg_decode u_dec (
        .nibble     (nibble_s),
        .unused_tie (1'b0),
        .seg        (seg_dec_s)
    );

    // State, counters, latched result and display outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            pass_r  <= '0;
            data_r  <= 8'h00;
            carry_r <= 1'b0;
            zero_r  <= 1'b0;
            seg_o   <= SEG_BLANK;
            dp_o    <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pass_r  <= pass_s;
            data_r  <= data_s;
            carry_r <= carry_s;
            zero_r  <= zero_s;
            busy_o  <= (state_s != ST_IDLE);
            case (state_s)
                ST_SIGN: begin
                    seg_o <= data_s[7] ? SEG_MINUS : SEG_BLANK;
                    dp_o  <= 1'b0;
                end
                ST_HI: begin
                    seg_o <= seg_dec_s;
                    dp_o  <= carry_s;
                end
                ST_LO: begin
                    seg_o <= seg_dec_s;
                    dp_o  <= zero_s;
                end
                default: begin
                    seg_o <= SEG_BLANK;
                    dp_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with DWELL=4, BLANK=2, REPEAT=1.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic [6:0] seg_o;
    logic       dp_o;
    logic       busy_o;

    int passed = 0;
    int total  = 0;

    alu_result_display #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2),
        .REPEAT       (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_zero  (res_zero),
        .seg_o     (seg_o),
        .dp_o      (dp_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed {busy,dp,seg}=%h expected %h", tag, obs, exp);
    endtask

    // Check {busy,dp,seg} on n consecutive cycles, sampling at the falling edge
    task automatic expect_for(input string tag, input logic [6:0] seg, input logic dp,
                              input logic busy, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, {busy_o, dp_o, seg_o}, {busy, dp, seg});
            @(negedge clk);
        end
    endtask

    // Present one result for a single rising edge; returns on the first display cycle
    task automatic send(input logic [7:0] d, input logic c, input logic z);
        res_valid = 1'b1;
        res_data  = d;
        res_carry = c;
        res_zero  = z;
        @(negedge clk);
        res_valid = 1'b0;
        res_data  = 8'h00;
    endtask

    initial begin
        rst_n     = 1'b0;
        ena       = 1'b1;
        res_valid = 1'b0;
        res_data  = 8'h00;
        res_carry = 1'b0;
        res_zero  = 1'b0;
        @(negedge clk);
        chk("reset_out", {busy_o, dp_o, seg_o}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", {8'h00, res_ready}, 9'h001);
        @(negedge clk);
        expect_for("idle", 7'h00, 1'b0, 1'b0, 2);

        // Full sequence for 0xA5
        send(8'hA5, 1'b1, 1'b0);
        expect_for("a5_hi", 7'h77, 1'b1, 1'b1, 4);
        expect_for("a5_lo", 7'h6D, 1'b0, 1'b1, 4);
        expect_for("a5_gap", 7'h00, 1'b0, 1'b1, 2);
        expect_for("a5_idle", 7'h00, 1'b0, 1'b0, 3);

        // Preempt during the second LO cycle
        send(8'hA5, 1'b1, 1'b0);
        expect_for("pre_hi", 7'h77, 1'b1, 1'b1, 4);
        expect_for("pre_lo", 7'h6D, 1'b0, 1'b1, 1);
        send(8'h3C, 1'b1, 1'b0);
        expect_for("3c_hi", 7'h4F, 1'b1, 1'b1, 4);
        expect_for("3c_lo", 7'h39, 1'b0, 1'b1, 4);
        expect_for("3c_gap", 7'h00, 1'b0, 1'b1, 2);
        expect_for("3c_idle", 7'h00, 1'b0, 1'b0, 1);

        // Freeze for three edges while HI of 0x12 is showing
        send(8'h12, 1'b0, 1'b1);
        expect_for("12_hi_a", 7'h06, 1'b0, 1'b1, 1);
        ena       = 1'b0;
        res_valid = 1'b1;
        res_data  = 8'hFF;
        res_carry = 1'b1;
        #1;
        chk("ready_low", {8'h00, res_ready}, 9'h000);
        chk("12_frozen_b", {busy_o, dp_o, seg_o}, {1'b1, 1'b0, 7'h06});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("12_frozen", {busy_o, dp_o, seg_o}, {1'b1, 1'b0, 7'h06});
            chk("ready_low_hold", {8'h00, res_ready}, 9'h000);
        end
        ena       = 1'b1;
        res_valid = 1'b0;
        res_data  = 8'h00;
        res_carry = 1'b0;
        expect_for("12_hi_b", 7'h06, 1'b0, 1'b1, 3);
        expect_for("12_lo", 7'h5B, 1'b1, 1'b1, 4);
        expect_for("12_gap", 7'h00, 1'b0, 1'b1, 2);
        expect_for("12_idle", 7'h00, 1'b0, 1'b0, 1);

        // Asynchronous reset between edges in the middle of LO
        send(8'hA5, 1'b1, 1'b0);
        expect_for("rst_hi", 7'h77, 1'b1, 1'b1, 4);
        expect_for("rst_lo", 7'h6D, 1'b0, 1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {busy_o, dp_o, seg_o}, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        expect_for("post_rst_idle", 7'h00, 1'b0, 1'b0, 2);
        send(8'h00, 1'b0, 1'b1);
        expect_for("00_hi", 7'h3F, 1'b0, 1'b1, 4);
        expect_for("00_lo", 7'h3F, 1'b1, 1'b1, 4);
        expect_for("00_gap", 7'h00, 1'b0, 1'b1, 2);
        expect_for("00_idle", 7'h00, 1'b0, 1'b0, 1);

`ifdef DISP_SIGNED_EN
        send(8'hFB, 1'b1, 1'b0);
        expect_for("fb_sign", 7'h40, 1'b0, 1'b1, 4);
        expect_for("fb_hi", 7'h3F, 1'b1, 1'b1, 4);
        expect_for("fb_lo", 7'h6D, 1'b0, 1'b1, 4);
        expect_for("fb_gap", 7'h00, 1'b0, 1'b1, 2);
        expect_for("fb_idle", 7'h00, 1'b0, 1'b0, 1);
        send(8'h05, 1'b0, 1'b0);
        expect_for("05_sign", 7'h00, 1'b0, 1'b1, 4);
        expect_for("05_hi", 7'h3F, 1'b0, 1'b1, 4);
        expect_for("05_lo", 7'h6D, 1'b0, 1'b1, 4);
        expect_for("05_gap", 7'h00, 1'b0, 1'b1, 2);
        expect_for("05_idle", 7'h00, 1'b0, 1'b0, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
